// File: rtl/pwm_pkg.sv
// Shared types and default constants for the pwm generator/capture pair.
package pwm_pkg;
  typedef enum logic {IDLE, MEAS} state_t;

  localparam int PWM_N       = 9;
  localparam int PWM_CNT_W   = 11;
  localparam int PWM_TIMEOUT = 1024;
endpackage

// File: rtl/pwm_edge_sync.sv
// 2-FF synchronizer plus delay flop for an asynchronous input; emits level and rise/fall strobes.
// Latency: rise/fall are asserted two clocks after the input is first sampled.
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM waveform, reporting once per period.
// Declares a stuck input after TIMEOUT edge-free clocks and re-arms on the next rise.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int N       = PWM_N,
  parameter int W       = PWM_CNT_W,
  parameter int TIMEOUT = 2 * (2 ** N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [W-1:0] high_time,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         stuck,
  output logic         stuck_level
);
  localparam logic [W-1:0] MAXV  = {W{1'b1}};
  localparam logic [W-1:0] TO    = W'(TIMEOUT);
  localparam logic [W-1:0] TO_M1 = W'(TIMEOUT - 1);

  logic level, rise, fall, any_edge, timeout;

  pwm_edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_t       state_q, state_d;
  logic [W-1:0] high_cnt_q, high_cnt_d;
  logic [W-1:0] period_cnt_q, period_cnt_d;
  logic [W-1:0] idle_cnt_q, idle_cnt_d;
  logic [W-1:0] high_time_d, period_d;
  logic         valid_d, stuck_d, stuck_level_d;

  assign any_edge = rise | fall;
  // Fires only on the cycle idle_cnt steps onto TIMEOUT, so a held timeout reports once.
  assign timeout  = ~any_edge && (idle_cnt_q == TO_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      idle_cnt_q   <= '0;
      high_time    <= '0;
      period       <= '0;
      valid        <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      high_time    <= high_time_d;
      period       <= period_d;
      valid        <= valid_d;
      stuck        <= stuck_d;
      stuck_level  <= stuck_level_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    period_cnt_d  = period_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    high_time_d   = high_time;
    period_d      = period;
    valid_d       = 1'b0;
    stuck_d       = stuck;
    stuck_level_d = stuck_level;

    if (any_edge)
      idle_cnt_d = '0;
    else if (idle_cnt_q != TO)
      idle_cnt_d = idle_cnt_q + W'(1);

    case (state_q)
      IDLE: begin
        if (rise) begin
          high_cnt_d   = W'(1);
          period_cnt_d = W'(1);
          stuck_d      = 1'b0;
          state_d      = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          high_time_d  = high_cnt_q;
          period_d     = period_cnt_q;
          valid_d      = 1'b1;
          high_cnt_d   = W'(1);
          period_cnt_d = W'(1);
        end else begin
          if (period_cnt_q != MAXV)
            period_cnt_d = period_cnt_q + W'(1);
          if (level && (high_cnt_q != MAXV))
            high_cnt_d = high_cnt_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // timeout excludes any edge, so it never collides with the rise handling above
    if (timeout) begin
      stuck_d       = 1'b1;
      stuck_level_d = level;
      high_time_d   = '0;
      period_d      = '0;
      valid_d       = 1'b1;
      state_d       = IDLE;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture driven by an in-bench 512-clock PWM generator.
module tb_pwm_capture;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset;
  logic         pwm_in;
  logic [W-1:0] high_time, period;
  logic         valid, stuck, stuck_level;

  pwm_capture #(.N(9), .W(W), .TIMEOUT(1024)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .high_time   (high_time),
    .period      (period),
    .valid       (valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  int  n_pass = 0;
  int  n_total = 0;
  int  cnt = 511;
  int  duty = 0;
  bit  gen_en = 0;
  bit  force_mode = 0;
  bit  force_val = 0;
  int  vcount = 0;
  bit  prev_valid = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Generator: 512-clock period, high while cnt < duty; changes only on negedge.
  always @(negedge clk) begin
    if (gen_en) begin
      cnt    = (cnt + 1) % 512;
      pwm_in = force_mode ? force_val : (cnt < duty);
    end
  end

  // Every valid pulse must be a single cycle wide.
  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      check("valid_width", int'(prev_valid), 0);
    end
    prev_valid = valid;
  end

  task automatic wait_valid(input int budget, output bit ok, output int cycles);
    ok = 0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (valid) ok = 1;
    end
  endtask

  task automatic expect_report(input string name, input int budget, input int eh,
                               input int ep, input int es, output int cycles);
    bit ok;
    wait_valid(budget, ok, cycles);
    check({name, "_seen"}, int'(ok), 1);
    check({name, "_high"}, int'(high_time), eh);
    check({name, "_period"}, int'(period), ep);
    check({name, "_stuck"}, int'(stuck), es);
  endtask

  task automatic skip_valid(input int n);
    bit ok;
    int c;
    for (int i = 0; i < n; i++) wait_valid(1200, ok, c);
  endtask

  task automatic wait_cnt(input int target);
    int k = 0;
    @(posedge clk);
    while (cnt != target && k < 1100) begin
      @(posedge clk);
      k++;
    end
    check("wait_cnt", cnt, target);
  endtask

  typedef struct {
    int duty;
    int exp_high;
    int exp_period;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int cyc, v0, k;

    vecs[0] = '{3,   3,   512};
    vecs[1] = '{256, 256, 512};
    vecs[2] = '{511, 511, 512};
    vecs[3] = '{1,   1,   512};
    vecs[4] = '{100, 100, 512};

    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_high_time", int'(high_time), 0);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_stuck", int'(stuck), 0);
    check("rst_stuck_level", int'(stuck_level), 0);

    reset  = 1'b0;
    duty   = 3;
    gen_en = 1;

    // Steady-state duties: skip two reports to flush any straddling period.
    for (int i = 0; i < 5; i++) begin
      duty = vecs[i].duty;
      skip_valid(2);
      expect_report($sformatf("vec%0d", i), 1200, vecs[i].exp_high, vecs[i].exp_period, 0, cyc);
    end

    // Reset in the low phase with duty 200: first rise only arms, second reports.
    duty = 200;
    skip_valid(2);
    wait_cnt(300);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_high_time", int'(high_time), 0);
    check("midrst_period", int'(period), 0);
    check("midrst_valid", int'(valid), 0);
    reset = 1'b0;
    v0 = vcount;
    wait_cnt(10);
    check("midrst_first_rise_no_valid", vcount, v0);
    expect_report("midrst", 1200, 200, 512, 0, cyc);

    // Duty 5 -> 300 while high at cnt 3: straddling period is high continuously to 299.
    duty = 5;
    skip_valid(2);
    wait_cnt(3);
    duty = 300;
    expect_report("dchg_straddle", 1200, 300, 512, 0, cyc);
    expect_report("dchg_next", 1200, 300, 512, 0, cyc);

    // Duty 0: single stuck-low report roughly TIMEOUT clocks after the last fall.
    duty = 0;
    expect_report("stuck0", 1300, 0, 0, 1, cyc);
    check("stuck0_level", int'(stuck_level), 0);
    check("stuck0_delay_ge", int'(cyc >= 1020), 1);
    check("stuck0_delay_le", int'(cyc <= 1036), 1);
    wait_valid(1500, ok, cyc);
    check("stuck0_no_repeat", int'(ok), 0);

    // Forced high: rise clears stuck, then stuck-high after TIMEOUT, no repeats.
    force_val  = 1;
    force_mode = 1;
    repeat (10) @(negedge clk);
    check("force1_rise_clears_stuck", int'(stuck), 0);
    expect_report("stuck1", 1300, 0, 0, 1, cyc);
    check("stuck1_level", int'(stuck_level), 1);
    wait_valid(960, ok, cyc);
    check("stuck1_no_repeat", int'(ok), 0);

    // Recovery with duty 100: stuck clears at first rise without a report.
    v0 = vcount;
    force_mode = 0;
    duty = 100;
    k = 0;
    while (stuck && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("recover_stuck_clear", int'(stuck), 0);
    check("recover_no_valid_on_rise", vcount, v0);
    expect_report("recover", 1200, 100, 512, 0, cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
